dispatch_rat: RTL

- Dispatch stage directly downstream of the instruction decoder in the out-of-order MIPS core.
- Takes one decoded instruction per cycle: op, register specifiers, extended immediate, PC.
- Allocates a ROB tag and renames the destination in a 32-entry register alias table (RAT).
- Resolves source operands to regfile, ROB or pending tag, then hands the instruction to the reservation station of its unit class (ALU/BU/DUL/DUS) through a registered valid/ready stage.

---
 rtl/dispatch_rat_pkg.sv | 42 ++++
 rtl/dispatch_rat_rat_table.sv | 80 ++++++++
 rtl/dispatch_rat.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dispatch_rat_pkg.sv
// Shared definitions for the dispatch / register-alias stage.
// Contents: unit class codes, ROB tag width, RAT entry and source-resolution
// structs, and a helper that maps a unit class onto its one-hot RS select.
package dispatch_rat_pkg;

  localparam int unsigned TAG_W = 4;

  localparam logic [2:0] CLS_ALU = 3'd1;
  localparam logic [2:0] CLS_BU  = 3'd2;
  localparam logic [2:0] CLS_DUL = 3'd3;
  localparam logic [2:0] CLS_DUS = 3'd4;

  // One alias-table entry: busy = a ROB entry owns the register,
  // ready = that producer has already broadcast its result.
  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [TAG_W-1:0] tag;
  } rat_entry_t;

  // Resolved source: busy = wait on CDB for tag, rob = read ROB at tag,
  // neither = read the architectural regfile.
  typedef struct packed {
    logic             busy;
    logic             rob;
    logic [TAG_W-1:0] tag;
  } src_info_t;

  // All-zero result marks an illegal class.
  function automatic logic [3:0] cls_onehot(input logic [2:0] cls);
    logic [3:0] sel;
    case (cls)
      CLS_ALU: sel = 4'b0001;
      CLS_BU:  sel = 4'b0010;
      CLS_DUL: sel = 4'b0100;
      CLS_DUS: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dispatch_rat_rat_table.sv
// Register alias table.
// Ports:
//   clk_i, rst_i, flush_i      clock, sync active-high reset, mispredict clear
//   rd1_addr_i/rd2_addr_i      source lookups -> rd1_o/rd2_o (resolved, with
//                              same-cycle CDB and commit bypass)
//   ren_en_i/ren_addr_i/ren_tag_i   rename write port
//   cdb_valid_i/cdb_tag_i      result broadcast, marks matching entries ready
//   cmt_valid_i/cmt_tag_i/cmt_rdst_i  commit, frees the entry if still owned
module rat_table
  import dispatch_rat_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [4:0]       rd1_addr_i,
  input  logic [4:0]       rd2_addr_i,
  output src_info_t        rd1_o,
  output src_info_t        rd2_o,
  input  logic             ren_en_i,
  input  logic [4:0]       ren_addr_i,
  input  logic [TAG_W-1:0] ren_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic             cmt_valid_i,
  input  logic [TAG_W-1:0] cmt_tag_i,
  input  logic [4:0]       cmt_rdst_i
);

  rat_entry_t rat_q [NREG];

  // Broadcasts are meaningless during a flush cycle.
  logic cdb_hit, cmt_hit;
  assign cdb_hit = cdb_valid_i & ~flush_i;
  assign cmt_hit = cmt_valid_i & ~flush_i;

  // Commit bypass wins over CDB bypass: once committed the value lives in
  // the regfile and the ROB slot is being released at this edge.
  function automatic src_info_t resolve(input logic [4:0] addr, input rat_entry_t e,
                                        input logic cdb_v, input logic [TAG_W-1:0] cdb_t,
                                        input logic cmt_v, input logic [TAG_W-1:0] cmt_t);
    src_info_t s;
    s = '0;
    if (addr != 5'd0 && e.busy) begin
      if (cmt_v && cmt_t == e.tag) begin
        s = '0;
      end else if (e.ready || (cdb_v && cdb_t == e.tag)) begin
        s.rob = 1'b1;
        s.tag = e.tag;
      end else begin
        s.busy = 1'b1;
        s.tag  = e.tag;
      end
    end
    return s;
  endfunction

  always_comb begin
    rd1_o = resolve(rd1_addr_i, rat_q[rd1_addr_i], cdb_hit, cdb_tag_i, cmt_hit, cmt_tag_i);
    rd2_o = resolve(rd2_addr_i, rat_q[rd2_addr_i], cdb_hit, cdb_tag_i, cmt_hit, cmt_tag_i);
  end

  // Per-entry priority: rename > commit > CDB. Entry 0 is never renamed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst_i || flush_i) begin
        rat_q[i] <= '0;
      end else if (ren_en_i && i != 0 && ren_addr_i == 5'(i)) begin
        rat_q[i] <= '{busy: 1'b1, ready: 1'b0, tag: ren_tag_i};
      end else if (cmt_hit && cmt_rdst_i == 5'(i) && rat_q[i].busy &&
                   rat_q[i].tag == cmt_tag_i) begin
        rat_q[i] <= '0;
      end else if (cdb_hit && rat_q[i].busy && rat_q[i].tag == cdb_tag_i) begin
        rat_q[i].ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispatch_rat.sv
// Dispatch stage: allocates a ROB tag, renames the destination in the RAT,
// resolves both sources and presents the instruction to one reservation
// station through a registered valid/ready stage.
// Ports:
//   clk, rst, flush                 clock, sync reset, mispredict recovery
//   dec_*                           decoded instruction in, dec_ready back
//   rob_free, rob_tag, rob_alloc    ROB allocation handshake
//   cdb_*, cmt_*                    result broadcast and in-order commit
//   rs_ready, rs_valid              per-class RS handshake (bit = class-1)
//   dsp_*                           registered instruction and resolved sources
module dispatch_rat #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [8:0]        dec_aluop,
  input  logic              dec_regw,
  input  logic [4:0]        dec_rsrc1,
  input  logic [4:0]        dec_rsrc2,
  input  logic [4:0]        dec_rdst,
  input  logic [DATA_W-1:0] dec_imm,
  input  logic [DATA_W-1:0] dec_pc,
  output logic              dec_ready,
  input  logic              rob_free,
  input  logic [TAG_W-1:0]  rob_tag,
  output logic              rob_alloc,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              cmt_valid,
  input  logic [TAG_W-1:0]  cmt_tag,
  input  logic [4:0]        cmt_rdst,
  input  logic [3:0]        rs_ready,
  output logic [3:0]        rs_valid,
  output logic [8:0]        dsp_op,
  output logic [DATA_W-1:0] dsp_imm,
  output logic [DATA_W-1:0] dsp_pc,
  output logic [TAG_W-1:0]  dsp_tag,
  output logic [4:0]        dsp_rdst,
  output logic              dsp_regw,
  output logic [4:0]        dsp_src1_reg,
  output logic [4:0]        dsp_src2_reg,
  output logic [TAG_W-1:0]  dsp_src1_tag,
  output logic [TAG_W-1:0]  dsp_src2_tag,
  output logic              dsp_src1_busy,
  output logic              dsp_src2_busy,
  output logic              dsp_src1_rob,
  output logic              dsp_src2_rob
);
  import dispatch_rat_pkg::*;

  logic [3:0]        rs_valid_q;
  logic [8:0]        op_q;
  logic [DATA_W-1:0] imm_q, pc_q;
  logic [TAG_W-1:0]  tag_q, src1_tag_q, src2_tag_q;
  logic [4:0]        rdst_q, src1_reg_q, src2_reg_q;
  logic              regw_q, src1_busy_q, src2_busy_q, src1_rob_q, src2_rob_q;

  logic [3:0] cls_sel;
  logic       out_valid, out_fire, fire_in, rename_en;
  src_info_t  src1, src2;

  always_comb begin
    cls_sel   = cls_onehot(dec_aluop[8:6]);
    out_valid = |rs_valid_q;
    out_fire  = |(rs_valid_q & rs_ready);
    dec_ready = !rst && !flush && rob_free && (!out_valid || out_fire);
    fire_in   = dec_valid && dec_ready;
    // Illegal classes are consumed but never reach the ROB or an RS.
    rob_alloc = fire_in && (cls_sel != 4'b0000);
    rename_en = rob_alloc && dec_regw && (dec_rdst != 5'd0);
  end

  rat_table #(
    .NREG (NREG)
  ) u_rat (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .rd1_addr_i  (dec_rsrc1),
    .rd2_addr_i  (dec_rsrc2),
    .rd1_o       (src1),
    .rd2_o       (src2),
    .ren_en_i    (rename_en),
    .ren_addr_i  (dec_rdst),
    .ren_tag_i   (rob_tag),
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .cmt_valid_i (cmt_valid),
    .cmt_tag_i   (cmt_tag),
    .cmt_rdst_i  (cmt_rdst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_valid_q  <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      tag_q       <= '0;
      rdst_q      <= '0;
      regw_q      <= 1'b0;
      src1_reg_q  <= '0;
      src2_reg_q  <= '0;
      src1_tag_q  <= '0;
      src2_tag_q  <= '0;
      src1_busy_q <= 1'b0;
      src2_busy_q <= 1'b0;
      src1_rob_q  <= 1'b0;
      src2_rob_q  <= 1'b0;
    end else if (flush) begin
      rs_valid_q <= '0;
    end else if (rob_alloc) begin
      rs_valid_q  <= cls_sel;
      op_q        <= dec_aluop;
      imm_q       <= dec_imm;
      pc_q        <= dec_pc;
      tag_q       <= rob_tag;
      rdst_q      <= dec_rdst;
      regw_q      <= dec_regw;
      src1_reg_q  <= dec_rsrc1;
      src2_reg_q  <= dec_rsrc2;
      src1_tag_q  <= src1.tag;
      src2_tag_q  <= src2.tag;
      src1_busy_q <= src1.busy;
      src2_busy_q <= src2.busy;
      src1_rob_q  <= src1.rob;
      src2_rob_q  <= src2.rob;
    end else if (out_fire) begin
      rs_valid_q <= '0;
    end else if (cdb_valid) begin
      // A stalled instruction must still observe broadcasts for its sources.
      if (src1_busy_q && src1_tag_q == cdb_tag) begin
        src1_busy_q <= 1'b0;
        src1_rob_q  <= 1'b1;
      end
      if (src2_busy_q && src2_tag_q == cdb_tag) begin
        src2_busy_q <= 1'b0;
        src2_rob_q  <= 1'b1;
      end
    end
  end

  assign rs_valid      = rs_valid_q;
  assign dsp_op        = op_q;
  assign dsp_imm       = imm_q;
  assign dsp_pc        = pc_q;
  assign dsp_tag       = tag_q;
  assign dsp_rdst      = rdst_q;
  assign dsp_regw      = regw_q;
  assign dsp_src1_reg  = src1_reg_q;
  assign dsp_src2_reg  = src2_reg_q;
  assign dsp_src1_tag  = src1_tag_q;
  assign dsp_src2_tag  = src2_tag_q;
  assign dsp_src1_busy = src1_busy_q;
  assign dsp_src2_busy = src2_busy_q;
  assign dsp_src1_rob  = src1_rob_q;
  assign dsp_src2_rob  = src2_rob_q;

endmodule
